// File: rtl/mem_io_pkg.sv
// Shared types for the memory/IO fabric: target ids, wait-FSM states and
// default address-map constants.
package mem_io_pkg;

    localparam int          RAM_AW_DEF  = 11;
    localparam logic [15:0] IO_BASE_DEF = 16'h1000;

    typedef enum logic [1:0] {
        TGT_NONE = 2'd0,
        TGT_RAM  = 2'd1,
        TGT_SLOT = 2'd2
    } tgt_kind_e;

    typedef struct packed {
        tgt_kind_e  kind;
        logic [3:0] slot;
    } tgt_id_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } wait_state_e;

    localparam tgt_id_t TGT_ID_NONE = '{kind: TGT_NONE, slot: 4'd0};

endpackage

// File: rtl/mem_io_decode.sv
// Combinational address decode: RAM window, per-slot IO windows, unmapped.
module mem_io_decode
    import mem_io_pkg::*;
#(
    parameter int          N_SLOTS = 4,
    parameter int          RAM_AW  = RAM_AW_DEF,
    parameter logic [15:0] IO_BASE = IO_BASE_DEF,
    parameter int          SLOT_AW = 4
) (
    input  logic [15:0]        i_address,
    output logic               o_ram_hit,
    output logic [N_SLOTS-1:0] o_slot_hit,
    output logic               o_unmapped
);

    logic [16:0] w_off;
    logic        w_in_page;
    logic        w_ram_hit;

    // 17-bit compare keeps RAM_AW=16 meaningful (whole space is RAM).
    assign w_ram_hit = ({1'b0, i_address} < (17'd1 << RAM_AW));
    assign w_off     = {1'b0, i_address} - {1'b0, IO_BASE};
    assign w_in_page = (i_address >= IO_BASE) && (w_off < 17'd256);

    // RAM wins any overlap so at most one target is ever selected.
    for (genvar k = 0; k < N_SLOTS; k++) begin : g_slot
        assign o_slot_hit[k] = w_in_page && !w_ram_hit &&
                               ((w_off >> SLOT_AW) == 17'(k));
    end

    assign o_ram_hit  = w_ram_hit;
    assign o_unmapped = !w_ram_hit && !(|o_slot_hit);

endmodule

// File: rtl/mem_io_fabric.sv
// CPU data-bus fabric: RAM with optional wait states, N_SLOTS IO slots,
// 1-cycle read mux. Fault capture is built only with MEM_IO_FABRIC_FAULT_EN.
module mem_io_fabric
    import mem_io_pkg::*;
#(
    parameter int          N_SLOTS  = 4,
    parameter int          RAM_AW   = RAM_AW_DEF,
    parameter logic [15:0] IO_BASE  = IO_BASE_DEF,
    parameter int          SLOT_AW  = 4,
    parameter int          RAM_WAIT = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            address,
    input  logic                   w_en,
    input  logic                   r_en,
    output logic [7:0]             dout,
    output logic                   ready,
    output logic                   ram_w_en,
    output logic                   ram_r_en,
    output logic [RAM_AW-1:0]      ram_addr,
    input  logic [7:0]             ram_dout,
    output logic [N_SLOTS-1:0]     io_w_en,
    output logic [N_SLOTS-1:0]     io_r_en,
    output logic [7:0]             io_addr,
    input  logic [8*N_SLOTS-1:0]   io_dout,
    output logic                   fault_flag,
    input  logic                   fault_flag_clr,
    output logic [15:0]            fault_addr,
    output logic                   fault_wr
);

    logic               w_ram_hit;
    logic [N_SLOTS-1:0] w_slot_hit;
    logic               w_unmapped;
    logic               w_req;
    logic               w_ready;
    wait_state_e        r_state;
    wait_state_e        w_state_nxt;
    logic [2:0]         r_cnt;
    logic [2:0]         w_cnt_nxt;
    tgt_id_t            w_tgt;
    tgt_id_t            r_rsel;
    logic [3:0]         w_slot_idx;
    logic [7:0]         w_dout;

    mem_io_decode #(
        .N_SLOTS (N_SLOTS),
        .RAM_AW  (RAM_AW),
        .IO_BASE (IO_BASE),
        .SLOT_AW (SLOT_AW)
    ) u_decode (
        .i_address  (address),
        .o_ram_hit  (w_ram_hit),
        .o_slot_hit (w_slot_hit),
        .o_unmapped (w_unmapped)
    );

    assign w_req    = w_en | r_en;
    assign ram_addr = address[RAM_AW-1:0];
    assign io_addr  = address[7:0];

    // Wait-state FSM register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Wait-state FSM next state and ready; only RAM accesses ever stall.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b1;
        if (RAM_WAIT == 0) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req && w_ram_hit) begin
                        w_ready     = 1'b0;
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = 3'(RAM_WAIT - 1);
                    end else begin
                        w_ready     = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (!w_req) begin
                        w_ready     = 1'b0;
                        w_state_nxt = ST_IDLE;
                        w_cnt_nxt   = 3'd0;
                    end else if (r_cnt != 3'd0) begin
                        w_ready     = 1'b0;
                        w_cnt_nxt   = r_cnt - 3'd1;
                    end else begin
                        w_ready     = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_ready     = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 3'd0;
                end
            endcase
        end
    end

    assign ready    = w_ready;
    assign ram_r_en = r_en & w_ram_hit & w_ready;
    assign ram_w_en = w_en & w_ram_hit & w_ready;
    assign io_r_en  = {N_SLOTS{r_en & w_ready}} & w_slot_hit;
    assign io_w_en  = {N_SLOTS{w_en & w_ready}} & w_slot_hit;

    // Encode the decoded target into a read-select id.
    always_comb begin
        w_slot_idx = 4'd0;
        for (int k = 0; k < N_SLOTS; k++) begin
            w_slot_idx = w_slot_idx | (w_slot_hit[k] ? 4'(k) : 4'd0);
        end
        w_tgt.slot = w_slot_idx;
        w_tgt.kind = w_ram_hit ? TGT_RAM : ((|w_slot_hit) ? TGT_SLOT : TGT_NONE);
    end

    // Read-select register: remembers which source answers next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rsel <= TGT_ID_NONE;
        end else if (w_ready && r_en) begin
            r_rsel <= w_tgt;
        end else begin
            r_rsel <= TGT_ID_NONE;
        end
    end

    // Read-data mux driven by the registered select.
    always_comb begin
        w_dout = 8'h00;
        case (r_rsel.kind)
            TGT_RAM: w_dout = ram_dout;
            TGT_SLOT: begin
                for (int k = 0; k < N_SLOTS; k++) begin
                    w_dout = w_dout | ((r_rsel.slot == 4'(k)) ? io_dout[8*k +: 8] : 8'h00);
                end
            end
            default: w_dout = 8'h00;
        endcase
    end

    assign dout = w_dout;

`ifdef MEM_IO_FABRIC_FAULT_EN
    logic        r_fault_flag;
    logic [15:0] r_fault_addr;
    logic        r_fault_wr;
    logic        w_fault_req;
    logic        w_capture;

    // A fresh fault in the same cycle as a clear re-arms the capture.
    assign w_fault_req = w_unmapped & w_req & w_ready;
    assign w_capture   = w_fault_req & (~r_fault_flag | fault_flag_clr);

    // Fault capture registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fault_flag <= 1'b0;
            r_fault_addr <= 16'h0000;
            r_fault_wr   <= 1'b0;
        end else begin
            r_fault_flag <= w_fault_req ? 1'b1 : (fault_flag_clr ? 1'b0 : r_fault_flag);
            r_fault_addr <= w_capture ? address : r_fault_addr;
            r_fault_wr   <= w_capture ? w_en : r_fault_wr;
        end
    end

    assign fault_flag = r_fault_flag;
    assign fault_addr = r_fault_addr;
    assign fault_wr   = r_fault_wr;
`else
    logic w_unused_fault;

    assign w_unused_fault = fault_flag_clr ^ w_unmapped;
    assign fault_flag     = 1'b0;
    assign fault_addr     = 16'h0000;
    assign fault_wr       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_io_fabric.sv
// Randomised scoreboard bench for mem_io_fabric (RAM_WAIT=2, 4 slots).
module tb_mem_io_fabric;

    localparam int NS = 4;
    localparam int RW = 2;
`ifdef MEM_IO_FABRIC_FAULT_EN
    localparam bit FEN = 1'b1;
`else
    localparam bit FEN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [15:0]   address;
    logic          w_en, r_en;
    logic [7:0]    dout;
    logic          ready;
    logic          ram_w_en, ram_r_en;
    logic [10:0]   ram_addr;
    logic [7:0]    ram_dout;
    logic [NS-1:0] io_w_en, io_r_en;
    logic [7:0]    io_addr;
    logic [8*NS-1:0] io_dout;
    logic          fault_flag, fault_flag_clr, fault_wr;
    logic [15:0]   fault_addr;

    mem_io_fabric #(.N_SLOTS(NS), .RAM_AW(11), .IO_BASE(16'h1000), .SLOT_AW(4), .RAM_WAIT(RW)) dut (
        .clk(clk), .rst_n(rst_n), .address(address), .w_en(w_en), .r_en(r_en),
        .dout(dout), .ready(ready), .ram_w_en(ram_w_en), .ram_r_en(ram_r_en),
        .ram_addr(ram_addr), .ram_dout(ram_dout), .io_w_en(io_w_en), .io_r_en(io_r_en),
        .io_addr(io_addr), .io_dout(io_dout), .fault_flag(fault_flag),
        .fault_flag_clr(fault_flag_clr), .fault_addr(fault_addr), .fault_wr(fault_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        bit          we;
        bit          re;
        logic [7:0]  data;
    } item_t;

    item_t q[$];
    int    n_chk = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Address map from first principles: 16 = RAM, 0..15 = slot, -1 = unmapped.
    function automatic int classify(input logic [15:0] a);
        if (a < 16'd2048) return 16;
        if (a >= 16'h1000 && a < 16'h1000 + 16'(NS * 16)) return (int'(a) - 32'h1000) / 16;
        return -1;
    endfunction

    // Monitor / reference model.
    int          stall = 0;
    logic [7:0]  dout_exp = 8'h00;
    bit          m_flag = 1'b0;
    logic [15:0] m_addr = 16'h0000;
    bit          m_wr = 1'b0;

    always @(negedge clk) begin
        item_t      it;
        int         c;
        bit         done;
        bit         fr;
        logic [7:0] nxt;
        if (mon_en) begin
            nxt = 8'h00;
            fr  = 1'b0;
            chk("dout", 32'(dout), 32'(dout_exp));
            chk("fault_flag", 32'(fault_flag), 32'(FEN & m_flag));
            chk("fault_addr", 32'(fault_addr), FEN ? 32'(m_addr) : 32'd0);
            chk("fault_wr", 32'(fault_wr), 32'(FEN & m_wr));
            if (w_en || r_en) begin
                if (q.size() == 0) begin
                    chk("sb_depth", 32'(q.size()), 32'd1);
                end else begin
                    it   = q[0];
                    c    = classify(it.addr);
                    done = (stall == ((c == 16) ? RW : 0));
                    chk("ready", 32'(ready), 32'(done));
                    if (done) begin
                        chk("ram_r_en", 32'(ram_r_en), 32'(it.re && c == 16));
                        chk("ram_w_en", 32'(ram_w_en), 32'(it.we && c == 16));
                        chk("io_r_en", 32'(io_r_en), (it.re && c >= 0 && c < 16) ? (32'd1 << c) : 32'd0);
                        chk("io_w_en", 32'(io_w_en), (it.we && c >= 0 && c < 16) ? (32'd1 << c) : 32'd0);
                        chk("ram_addr", 32'(ram_addr), 32'(it.addr) % 32'd2048);
                        chk("io_addr", 32'(io_addr), 32'(it.addr) & 32'hFF);
                        nxt = (it.re && c >= 0) ? it.data : 8'h00;
                        fr  = (c < 0);
                        void'(q.pop_front());
                        stall = 0;
                    end else begin
                        chk("stall_strobes", {ram_r_en, ram_w_en, io_r_en, io_w_en}, 32'd0);
                        stall++;
                    end
                end
            end else begin
                chk("idle_ready", 32'(ready), 32'd1);
                chk("idle_strobes", {ram_r_en, ram_w_en, io_r_en, io_w_en}, 32'd0);
            end
            if (fr && (!m_flag || fault_flag_clr)) begin
                m_addr = address;
                m_wr   = w_en;
            end
            m_flag   = fr ? 1'b1 : (fault_flag_clr ? 1'b0 : m_flag);
            dout_exp = nxt;
        end
    end

    // One bus transaction followed by one idle cycle; data held stable throughout.
    task automatic access(input logic [15:0] a, input bit we, input bit re, input bit clr);
        item_t it;
        int    c;
        int    n;
        ram_dout = 8'($urandom_range(1, 255));
        io_dout  = $urandom;
        c = classify(a);
        it.addr = a;
        it.we   = we;
        it.re   = re;
        it.data = (c == 16) ? ram_dout : ((c >= 0 && c < 16) ? io_dout[8*c +: 8] : 8'h00);
        q.push_back(it);
        address = a; w_en = we; r_en = re; fault_flag_clr = clr;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ready && n < 20);
        if (!ready) chk("handshake_timeout", 32'(n), 32'd0);
        @(posedge clk); #1;
        w_en = 1'b0; r_en = 1'b0; fault_flag_clr = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a;
        int          sel;
        int          r;
        rst_n = 1'b0; address = 16'h0000; w_en = 1'b0; r_en = 1'b0;
        ram_dout = 8'h00; io_dout = '0; fault_flag_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_fault_flag", 32'(fault_flag), 32'd0);
        chk("rst_fault_addr", 32'(fault_addr), 32'd0);
        chk("rst_fault_wr", 32'(fault_wr), 32'd0);
        @(posedge clk); #1 mon_en = 1'b1;

        access(16'h0123, 1'b0, 1'b1, 1'b0);
        access(16'h1012, 1'b1, 1'b0, 1'b0);
        access(16'h3000, 1'b1, 1'b0, 1'b0);
        access(16'h4000, 1'b0, 1'b1, 1'b0);
        access(16'h5000, 1'b1, 1'b0, 1'b1);
        access(16'h0010, 1'b0, 1'b1, 1'b1);
        access(16'h0010, 1'b1, 1'b1, 1'b0);
        access(16'h1035, 1'b0, 1'b1, 1'b0);
        access(16'h103F, 1'b1, 1'b1, 1'b0);
        access(16'h1040, 1'b0, 1'b1, 1'b0);
        access(16'h07FF, 1'b0, 1'b1, 1'b0);
        access(16'h0800, 1'b0, 1'b1, 1'b1);
        access(16'h1000, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < 120; i++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: a = 16'($urandom_range(0, 2047));
                1: a = 16'h1000 + 16'($urandom_range(0, NS * 16 - 1));
                2: a = 16'h1040 + 16'($urandom_range(0, 191));
                default: a = 16'($urandom_range(32'h0800, 32'hFFFF));
            endcase
            r = $urandom_range(1, 3);
            access(a, r[0], r[1], $urandom_range(0, 3) == 0);
        end
        chk("sb_drained", 32'(q.size()), 32'd0);

        // Abort: dropping the request mid-wait must not complete the access.
        mon_en = 1'b0;
        ram_dout = 8'h5C;
        address = 16'h0020; r_en = 1'b1;
        @(negedge clk);
        chk("abort_stall0", 32'(ready), 32'd0);
        @(posedge clk); #1 r_en = 1'b0;
        @(negedge clk);
        chk("abort_no_strobe", {ram_r_en, ram_w_en}, 32'd0);
        @(posedge clk); #1 r_en = 1'b1;
        @(negedge clk);
        chk("restart_stall0", {ready, ram_r_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("restart_stall1", {ready, ram_r_en}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("restart_done", {ready, ram_r_en}, 32'd3);
        @(posedge clk); #1 r_en = 1'b0;
        @(negedge clk);
        chk("restart_dout", 32'(dout), 32'h5C);
        @(posedge clk); #1;

        // Reset in the middle of a wait abandons the access.
        address = 16'h0010; r_en = 1'b1;
        @(negedge clk);
        chk("rstw_stall0", {ready, ram_r_en}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rstw_no_strobe", 32'(ram_r_en), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1; r_en = 1'b0;
        @(negedge clk);
        chk("rstw_ready", 32'(ready), 32'd1);
        chk("rstw_dout", 32'(dout), 32'd0);
        chk("rstw_no_strobe2", 32'(ram_r_en), 32'd0);
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
